// File: rtl/adc0832_pkg.sv
// Shared constants for the ADC0832 scan scheduler.
// FSM encodings, core select codes and default sizing.
package adc0832_pkg;

    localparam int AVG_LOG2_DEF = 2;
    localparam int TIMEOUT_DEF  = 4096;

    localparam logic [1:0] SEL_IDLE = 2'b00;
    localparam logic [1:0] SEL_CH0  = 2'b01;
    localparam logic [1:0] SEL_CH1  = 2'b10;
    localparam logic [1:0] SEL_BOTH = 2'b11;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARM     = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;

    function automatic logic ch_on(
        input logic [1:0] mask,
        input logic [1:0] sel
    );
        return |(mask & sel);
    endfunction

endpackage

// File: rtl/adc0832_scan_sched_if.sv
// Bus between the scan scheduler and the ADC0832 core.
// The scheduler is master: it drives select and restart.
interface adc0832_scan_sched_if;

    logic [1:0] adc_sel;
    logic       adc_rst;
    logic       adc_finish;
    logic [7:0] adc_ch0;
    logic [7:0] adc_ch1;

    modport master (
        output adc_sel,
        output adc_rst,
        input  adc_finish,
        input  adc_ch0,
        input  adc_ch1
    );

    modport slave (
        input  adc_sel,
        input  adc_rst,
        output adc_finish,
        output adc_ch0,
        output adc_ch1
    );

endinterface

// File: rtl/adc0832_avg_acc.sv
// Per-channel boxcar accumulator and average register.
// clr beats dump; dump folds in the final sample.
module adc0832_avg_acc
    import adc0832_pkg::*;
#(
    parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       add_en,
    input  logic       dump,
    input  logic       clr,
    input  logic [7:0] din,
    output logic [7:0] avg
);

    localparam int AW = 8 + AVG_LOG2;

    logic [AW-1:0] acc_q, acc_d, sum;
    logic [7:0]    avg_q, avg_d;

    assign sum = acc_q + AW'(din);
    assign avg = avg_q;

    // Accumulate a sample, or publish the truncated mean.
    always_comb begin
        acc_d = acc_q;
        avg_d = avg_q;
        if (clr) begin
            acc_d = '0;
        end else if (add_en) begin
            if (dump) begin
                avg_d = sum[AW-1:AVG_LOG2];
                acc_d = '0;
            end else begin
                acc_d = sum;
            end
        end
    end

    // Accumulator and average state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            avg_q <= '0;
        end else begin
            acc_q <= acc_d;
            avg_q <= avg_d;
        end
    end

endmodule

// File: rtl/adc0832_scan_sched.sv
// Periodic sampling scheduler for the ADC0832 core.
// Sequences conversions, averages both channels, raises alarms.
module adc0832_scan_sched
    import adc0832_pkg::*;
#(
    parameter int PERIOD_W = 24,
    parameter int AVG_LOG2 = AVG_LOG2_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          ch_mask,
    input  logic [PERIOD_W-1:0] period,
    input  logic [7:0]          thr_hi,
    input  logic                alarm_clr,
    adc0832_scan_sched_if.master adc,
    output logic [7:0]          avg_ch0,
    output logic [7:0]          avg_ch1,
    output logic                valid,
    output logic [1:0]          alarm,
    output logic                timeout_err
);

    localparam logic [PERIOD_W-1:0] TO_LAST =
        PERIOD_W'(TIMEOUT - 1);
    localparam logic [AVG_LOG2:0] CNT_LAST =
        (AVG_LOG2 + 1)'(2 ** AVG_LOG2 - 1);

    logic [2:0]          state_q, state_d;
    logic [PERIOD_W-1:0] tmr_q, tmr_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [AVG_LOG2:0]   cnt_q, cnt_d;
    logic [1:0]          mask_q, mask_d;
    logic [1:0]          vld_q, vld_d;
    logic [1:0]          alarm_q, alarm_d;
    logic                fin_q, fin_d;
    logic                to_q, to_d;
    logic                capture, last, fin_edge;
    logic                add0, add1;

    assign fin_d    = adc.adc_finish;
    assign fin_edge = adc.adc_finish & ~fin_q;
    assign last     = (cnt_q == CNT_LAST);

    assign add0  = capture & ch_on(mask_q, SEL_CH0);
    assign add1  = capture & ch_on(mask_q, SEL_CH1);
    assign vld_d = {add1 & last, add0 & last};

    assign adc.adc_sel = (state_q == ST_IDLE) ? SEL_IDLE : mask_q;
    assign adc.adc_rst = (state_q == ST_ARM);
    assign valid       = |vld_q;
    assign alarm       = alarm_q;
    assign timeout_err = to_q;

    // Sequencer: arm, wait for finish, capture, hold off.
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        period_d = period_q;
        to_d     = to_q;
        capture  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en && ch_mask != SEL_IDLE)
                    state_d = ST_ARM;
            end
            ST_ARM: begin
                tmr_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (fin_edge) begin
                    state_d = ST_CAPTURE;
                end else if (tmr_q == TO_LAST) begin
                    to_d    = 1'b1;
                    state_d = ST_ARM;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_CAPTURE: begin
                capture = 1'b1;
                tmr_d   = '0;
                cnt_d   = last ? '0 : cnt_q + 1'b1;
                state_d = (period_q == '0) ? ST_ARM
                                           : ST_HOLD;
            end
            ST_HOLD: begin
                if (tmr_q == period_q - 1'b1)
                    state_d = ST_ARM;
                else
                    tmr_d = tmr_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!en) begin
            state_d = ST_IDLE;
            tmr_d   = '0;
            cnt_d   = '0;
            capture = 1'b0;
        end
        if (state_d == ST_ARM) begin
            mask_d   = ch_mask & SEL_BOTH;
            period_d = period;
        end
    end

    // Sticky alarm; a new set outranks a clear.
    always_comb begin
        alarm_d = alarm_q;
        if (alarm_clr)
            alarm_d = '0;
        if (vld_q[0] && avg_ch0 > thr_hi)
            alarm_d[0] = 1'b1;
        if (vld_q[1] && avg_ch1 > thr_hi)
            alarm_d[1] = 1'b1;
    end

    // Scheduler state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            tmr_q    <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            mask_q   <= '0;
            vld_q    <= '0;
            alarm_q  <= '0;
            fin_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            vld_q    <= vld_d;
            alarm_q  <= alarm_d;
            fin_q    <= fin_d;
            to_q     <= to_d;
        end
    end

    adc0832_avg_acc #(.AVG_LOG2(AVG_LOG2)) u_acc0 (
        .clk    (clk),
        .rst    (rst),
        .add_en (add0),
        .dump   (last),
        .clr    (~en),
        .din    (adc.adc_ch0),
        .avg    (avg_ch0)
    );

    adc0832_avg_acc #(.AVG_LOG2(AVG_LOG2)) u_acc1 (
        .clk    (clk),
        .rst    (rst),
        .add_en (add1),
        .dump   (last),
        .clr    (~en),
        .din    (adc.adc_ch1),
        .avg    (avg_ch1)
    );

endmodule

// File: tb/tb_adc0832_scan_sched.sv
// Directed bench for the ADC0832 scan scheduler.
// Plays the core's finish/data side and checks every output.
module tb_adc0832_scan_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  ch_mask;
    logic [23:0] period;
    logic [7:0]  thr_hi;
    logic        alarm_clr;
    logic [7:0]  avg_ch0, avg_ch1;
    logic        valid;
    logic [1:0]  alarm;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    int vcnt    = 0;
    int gap;
    int v0;

    adc0832_scan_sched_if adc_if();

    adc0832_scan_sched dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .ch_mask     (ch_mask),
        .period      (period),
        .thr_hi      (thr_hi),
        .alarm_clr   (alarm_clr),
        .adc         (adc_if),
        .avg_ch0     (avg_ch0),
        .avg_ch1     (avg_ch1),
        .valid       (valid),
        .alarm       (alarm),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Running count of valid pulses.
    always @(posedge clk)
        if (valid) vcnt <= vcnt + 1;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic wait_arm(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (adc_if.adc_rst !== 1'b1 && n < 5000);
        chk("arm_seen", 32'(adc_if.adc_rst), 1);
    endtask

    // Called at the ARM negedge; finish edge 3 cycles later.
    task automatic fire(input logic [7:0] d0,
                        input logic [7:0] d1);
        adc_if.adc_finish = 1'b0;
        adc_if.adc_ch0    = d0;
        adc_if.adc_ch1    = d1;
        repeat (3) @(negedge clk);
        adc_if.adc_finish = 1'b1;
    endtask

    task automatic conv(input logic [7:0] d0,
                        input logic [7:0] d1);
        int n;
        wait_arm(n);
        fire(d0, d1);
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        ch_mask   = 2'b11;
        period    = 24'd4;
        thr_hi    = 8'hFF;
        alarm_clr = 1'b0;
        adc_if.adc_finish = 1'b0;
        adc_if.adc_ch0    = 8'h00;
        adc_if.adc_ch1    = 8'h00;

        // reset held with en high
        repeat (3) @(negedge clk);
        chk("rst_sel", 32'(adc_if.adc_sel), 0);
        chk("rst_adc_rst", 32'(adc_if.adc_rst), 0);
        chk("rst_avg0", 32'(avg_ch0), 0);
        chk("rst_avg1", 32'(avg_ch1), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_alarm", 32'(alarm), 0);
        chk("rst_to", 32'(timeout_err), 0);
        en  = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_sel", 32'(adc_if.adc_sel), 0);

        // mask 11, constant data
        en = 1'b1;
        @(negedge clk);
        chk("arm_lat", 32'(adc_if.adc_rst), 1);
        chk("arm_sel11", 32'(adc_if.adc_sel), 3);
        fire(8'h40, 8'h80);
        conv(8'h40, 8'h80);
        conv(8'h40, 8'h80);
        conv(8'h40, 8'h80);
        @(negedge clk);
        chk("t1_valid_n1", 32'(valid), 0);
        @(negedge clk);
        chk("t1_valid", 32'(valid), 1);
        chk("t1_avg0", 32'(avg_ch0), 'h40);
        chk("t1_avg1", 32'(avg_ch1), 'h80);
        @(negedge clk);
        chk("t1_vcnt", 32'(vcnt), 1);
        chk("t1_alarm", 32'(alarm), 0);

        // mask 01, truncating average
        ch_mask = 2'b01;
        thr_hi  = 8'h40;
        conv(8'h10, 8'h33);
        @(negedge clk);
        chk("t2_sel01", 32'(adc_if.adc_sel), 1);
        conv(8'h20, 8'h33);
        conv(8'h30, 8'h33);
        conv(8'h41, 8'h33);
        @(negedge clk);
        @(negedge clk);
        chk("t2_valid", 32'(valid), 1);
        chk("t2_avg0", 32'(avg_ch0), 'h28);
        chk("t2_avg1_hold", 32'(avg_ch1), 'h80);
        @(negedge clk);
        chk("t2_alarm", 32'(alarm), 0);
        chk("t2_vcnt", 32'(vcnt), 2);

        // average 0x41 over threshold 0x40
        for (int i = 0; i < 4; i++)
            conv(8'h41, 8'h33);
        @(negedge clk);
        @(negedge clk);
        chk("t3_avg0", 32'(avg_ch0), 'h41);
        @(negedge clk);
        chk("t3_alarm", 32'(alarm), 1);

        // clear in the set cycle, then a lone clear
        for (int i = 0; i < 4; i++)
            conv(8'h50, 8'h33);
        @(negedge clk);
        @(negedge clk);
        chk("t4_valid", 32'(valid), 1);
        alarm_clr = 1'b1;
        @(negedge clk);
        chk("t4_set_wins", 32'(alarm), 1);
        @(negedge clk);
        chk("t4_cleared", 32'(alarm), 0);
        alarm_clr = 1'b0;

        // hold spacing: period 10, then 0
        period = 24'd10;
        conv(8'h00, 8'h00);
        wait_arm(gap);
        chk("gap_p10", 32'(gap), 12);
        period = 24'd0;
        fire(8'h00, 8'h00);
        wait_arm(gap);
        chk("gap_p10_late", 32'(gap), 12);
        fire(8'h00, 8'h00);
        wait_arm(gap);
        chk("gap_p0", 32'(gap), 2);
        fire(8'h00, 8'h00);
        wait_arm(gap);
        chk("gap_p0_b", 32'(gap), 2);
        chk("t5_valid", 32'(valid), 1);
        chk("t5_avg0", 32'(avg_ch0), 0);

        // no finish: timeout and retry
        adc_if.adc_finish = 1'b0;
        wait_arm(gap);
        chk("to_gap", 32'(gap), 4097);
        chk("to_err", 32'(timeout_err), 1);

        // drop en after 2 samples
        period = 24'd4;
        fire(8'h10, 8'h00);
        conv(8'h10, 8'h00);
        @(negedge clk);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("off_sel", 32'(adc_if.adc_sel), 0);
        chk("off_rst", 32'(adc_if.adc_rst), 0);
        chk("off_to_hold", 32'(timeout_err), 1);
        v0 = vcnt;
        en = 1'b1;
        conv(8'h20, 8'h00);
        conv(8'h20, 8'h00);
        repeat (4) @(negedge clk);
        chk("off_no_valid", 32'(vcnt), 32'(v0));
        conv(8'h20, 8'h00);
        conv(8'h20, 8'h00);
        @(negedge clk);
        @(negedge clk);
        chk("off_valid", 32'(valid), 1);
        chk("off_avg0", 32'(avg_ch0), 'h20);
        @(negedge clk);
        chk("off_vcnt", 32'(vcnt), 32'(v0 + 1));

        // asynchronous reset between clock edges
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_avg0", 32'(avg_ch0), 0);
        chk("arst_sel", 32'(adc_if.adc_sel), 0);
        chk("arst_to", 32'(timeout_err), 0);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule
